// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared encodings and helpers for the pipeline hazard controller
package pipe_hazard_ctrl_pkg;
  typedef enum logic [1:0] {HZ_RUN = 2'd0, HZ_MWAIT = 2'd1, HZ_REDIR = 2'd2} hz_state_e;
  localparam logic [4:0] REG_ZERO = 5'd0;
  typedef struct packed {
    logic wreg;
    logic m2reg;
    logic wmem;
    logic branch;
  } ctrl_t;
  localparam ctrl_t BUBBLE = '0;
  function automatic logic raw_hit(input logic wreg, input logic [4:0] dst,
                                   input logic [4:0] rs, input logic use_rs,
                                   input logic [4:0] rt, input logic use_rt);
    return wreg && dst != REG_ZERO && ((use_rs && dst == rs) || (use_rt && dst == rt));
  endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_hz_sat_counter.sv
// hz_sat_counter: saturating event counter that sticks at all-ones
module hz_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/freeze control for the 5-stage pipeline registers
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter bit FWD      = 1'b1,
  parameter int BR_EXTRA = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             e_wreg,
  input  logic             e_m2reg,
  input  logic [4:0]       e_dst,
  input  logic             m_wreg,
  input  logic [4:0]       m_dst,
  input  logic             e_br_taken,
  input  logic             mem_busy,
  output logic             pc_we,
  output logic             pc_sel_br,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idexe_we,
  output logic             idexe_flush,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic [1:0]       hz_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam logic [1:0] SQ_INIT = 2'(BR_EXTRA);
  hz_state_e state, state_nx, ret, ret_nx, eff;
  logic [1:0] sq_cnt, sq_nx;
  logic raw_e, raw_m, data_hz;
  assign raw_e = raw_hit(e_wreg, e_dst, id_rs, id_use_rs, id_rt, id_use_rt);
  assign raw_m = raw_hit(m_wreg, m_dst, id_rs, id_use_rs, id_rt, id_use_rt);
  assign data_hz = FWD ? (raw_e & e_m2reg) : (raw_e | raw_m);
  // MWAIT remembers where it came from so the pipe resumes exactly there
  assign eff = state == HZ_MWAIT ? ret : state;
  assign hz_state = state;
  always_comb begin
    pc_we = 1'b1;
    pc_sel_br = 1'b0;
    ifid_we = 1'b1;
    ifid_flush = 1'b0;
    idexe_we = 1'b1;
    idexe_flush = 1'b0;
    exmem_we = 1'b1;
    memwb_we = 1'b1;
    state_nx = eff;
    ret_nx = ret;
    sq_nx = sq_cnt;
    if (rst) begin
      pc_we = 1'b0;
      ifid_flush = 1'b1;
      idexe_flush = 1'b1;
    end else if (mem_busy) begin
      pc_we = 1'b0;
      ifid_we = 1'b0;
      idexe_we = 1'b0;
      exmem_we = 1'b0;
      memwb_we = 1'b0;
      state_nx = HZ_MWAIT;
      ret_nx = eff;
    end else if (eff == HZ_REDIR) begin
      ifid_flush = 1'b1;
      sq_nx = sq_cnt - 2'd1;
      state_nx = sq_cnt == 2'd1 ? HZ_RUN : HZ_REDIR;
    end else if (e_br_taken) begin
      pc_sel_br = 1'b1;
      ifid_flush = 1'b1;
      idexe_flush = 1'b1;
      state_nx = BR_EXTRA > 0 ? HZ_REDIR : HZ_RUN;
      sq_nx = SQ_INIT;
    end else if (data_hz) begin
      pc_we = 1'b0;
      ifid_we = 1'b0;
      idexe_flush = 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= HZ_RUN;
      ret <= HZ_RUN;
      sq_cnt <= 2'd0;
    end else begin
      state <= state_nx;
      ret <= ret_nx;
      sq_cnt <= sq_nx;
    end
  hz_sat_counter #(.CNT_W(CNT_W)) u_stall (
    .clk(clk), .rst(rst), .inc(~pc_we), .cnt(stall_cnt)
  );
  hz_sat_counter #(.CNT_W(CNT_W)) u_flush (
    .clk(clk), .rst(rst), .inc(ifid_flush | idexe_flush), .cnt(flush_cnt)
  );
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: two configurations checked against a cycle-level reference model
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs, id_rt, e_dst, m_dst;
  logic id_use_rs, id_use_rt, e_wreg, e_m2reg, m_wreg, e_br_taken, mem_busy;
  logic pc_we[2], pc_sel_br[2], ifid_we[2], ifid_flush[2], idexe_we[2], idexe_flush[2];
  logic exmem_we[2], memwb_we[2];
  logic [1:0] hz_state[2];
  logic [15:0] stall_a, flush_a;
  logic [3:0] stall_b, flush_b;
  int n_vec = 0, n_err = 0, cyc = 0;
  int fwd_p[2] = '{1, 0};
  int brx_p[2] = '{2, 0};
  int max_p[2] = '{65535, 15};
  int m_wait[2], m_sq[2], m_stall[2], m_flush[2];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FWD(1'b1), .BR_EXTRA(2), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_dst(e_dst),
    .m_wreg(m_wreg), .m_dst(m_dst), .e_br_taken(e_br_taken), .mem_busy(mem_busy),
    .pc_we(pc_we[0]), .pc_sel_br(pc_sel_br[0]), .ifid_we(ifid_we[0]),
    .ifid_flush(ifid_flush[0]), .idexe_we(idexe_we[0]), .idexe_flush(idexe_flush[0]),
    .exmem_we(exmem_we[0]), .memwb_we(memwb_we[0]), .hz_state(hz_state[0]),
    .stall_cnt(stall_a), .flush_cnt(flush_a)
  );
  pipe_hazard_ctrl #(.FWD(1'b0), .BR_EXTRA(0), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_dst(e_dst),
    .m_wreg(m_wreg), .m_dst(m_dst), .e_br_taken(e_br_taken), .mem_busy(mem_busy),
    .pc_we(pc_we[1]), .pc_sel_br(pc_sel_br[1]), .ifid_we(ifid_we[1]),
    .ifid_flush(ifid_flush[1]), .idexe_we(idexe_we[1]), .idexe_flush(idexe_flush[1]),
    .exmem_we(exmem_we[1]), .memwb_we(memwb_we[1]), .hz_state(hz_state[1]),
    .stall_cnt(stall_b), .flush_cnt(flush_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic idle_in();
    rst = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; e_wreg = 0; e_m2reg = 0;
    e_dst = 0; m_wreg = 0; m_dst = 0; e_br_taken = 0; mem_busy = 0;
  endtask

  // Inputs are set just after a falling edge; outputs are checked before the next rising edge
  task automatic run_cycle();
    bit re, rm, hzd;
    logic [7:0] ctl;
    int st;
    #1;
    for (int i = 0; i < 2; i++) begin
      re = e_wreg && e_dst != 0 && ((id_use_rs && e_dst == id_rs) || (id_use_rt && e_dst == id_rt));
      rm = m_wreg && m_dst != 0 && ((id_use_rs && m_dst == id_rs) || (id_use_rt && m_dst == id_rt));
      hzd = fwd_p[i] != 0 ? (re && e_m2reg) : (re || rm);
      st = m_wait[i] != 0 ? 1 : (m_sq[i] > 0 ? 2 : 0);
      // {pc_we, pc_sel_br, ifid_we, ifid_flush, idexe_we, idexe_flush, exmem_we, memwb_we}
      if (rst) ctl = 8'b0011_1111;
      else if (mem_busy) ctl = 8'b0000_0000;
      else if (m_sq[i] > 0) ctl = 8'b1011_1011;
      else if (e_br_taken) ctl = 8'b1111_1111;
      else if (hzd) ctl = 8'b0000_1111;
      else ctl = 8'b1010_1011;
      chk($sformatf("ctl%0d", i),
          {22'd0, pc_we[i], pc_sel_br[i], ifid_we[i], ifid_flush[i], idexe_we[i],
           idexe_flush[i], exmem_we[i], memwb_we[i], hz_state[i]},
          {22'd0, ctl, 2'(st)});
      chk($sformatf("stall_cnt%0d", i), i == 0 ? 32'(stall_a) : 32'(stall_b), 32'(m_stall[i]));
      chk($sformatf("flush_cnt%0d", i), i == 0 ? 32'(flush_a) : 32'(flush_b), 32'(m_flush[i]));
      if (rst) begin
        m_wait[i] = 0; m_sq[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
      end else begin
        if (mem_busy) m_wait[i] = 1;
        else begin
          m_wait[i] = 0;
          if (m_sq[i] > 0) m_sq[i]--;
          else if (e_br_taken) m_sq[i] = brx_p[i];
        end
        if (!ctl[7] && m_stall[i] < max_p[i]) m_stall[i]++;
        if ((ctl[4] || ctl[2]) && m_flush[i] < max_p[i]) m_flush[i]++;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_wait[i] = 0; m_sq[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
    end
    idle_in(); rst = 1;
    @(negedge clk);
    #1; cyc++;
    @(negedge clk);
    run_cycle();
    idle_in(); e_wreg = 1; e_m2reg = 1; e_dst = 2; id_rs = 2; id_use_rs = 1;
    run_cycle();
    idle_in(); run_cycle();
    idle_in(); m_wreg = 1; m_dst = 5; id_rt = 5; id_use_rt = 1;
    run_cycle();
    idle_in(); e_wreg = 1; e_dst = 0; id_rs = 0; id_use_rs = 1;
    run_cycle();
    idle_in(); e_br_taken = 1; e_wreg = 1; e_m2reg = 1; e_dst = 3; id_rt = 3; id_use_rt = 1;
    run_cycle();
    idle_in(); run_cycle(); run_cycle(); run_cycle();
    e_br_taken = 1; run_cycle();
    idle_in(); run_cycle();
    mem_busy = 1; run_cycle(); run_cycle(); run_cycle();
    idle_in(); run_cycle(); run_cycle();
    e_br_taken = 1; run_cycle();
    idle_in(); rst = 1; run_cycle();
    idle_in(); run_cycle(); run_cycle();
    mem_busy = 1;
    for (int k = 0; k < 20; k++) run_cycle();
    idle_in(); run_cycle();
    for (int k = 0; k < 2000; k++) begin
      rst = $urandom_range(0, 79) == 0;
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      id_use_rs = 1'($urandom_range(0, 1));
      id_use_rt = 1'($urandom_range(0, 1));
      e_wreg = 1'($urandom_range(0, 1));
      e_m2reg = 1'($urandom_range(0, 1));
      e_dst = 5'($urandom_range(0, 3));
      m_wreg = 1'($urandom_range(0, 1));
      m_dst = 5'($urandom_range(0, 3));
      e_br_taken = $urandom_range(0, 7) == 0;
      mem_busy = $urandom_range(0, 5) == 0;
      run_cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
